ext_mem_bridge: RTL and testbench

EXT_MEM_BRIDGE -- requirements
Module: ext_mem_bridge

---
 rtl/ext_mem_bridge.sv | 100 ++++++++++
 tb/tb_ext_mem_bridge.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_bridge.sv
// CPU-to-external-memory handshake bridge: IDLE -> REQ -> DONE per access.
// Define EXT_TIMEOUT_EN to abort a REQ phase after TIMEOUT_CYCLES with bus_err.
module ext_mem_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic        ext_ack,
  input  logic [31:0] ext_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state;
  logic   pending;

  assign pending = cs & (cpu_we | cpu_re);
  // Gated by rst_n so the CPU is never held while the bridge is in reset.
  assign stall   = rst_n & (((state == IDLE) & pending) | (state == REQ));

`ifdef EXT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (state == IDLE)
      tmo_cnt <= '0;
    else if ((state == REQ) && !ext_ack && !tmo_hit)
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
      cpu_rdata <= '0;
`ifdef EXT_TIMEOUT_EN
      bus_err   <= 1'b0;
`endif
    end else begin
`ifdef EXT_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // A still-high ack from the previous access blocks the launch.
          if (pending && !ext_ack) begin
            ext_addr  <= cpu_addr;
            ext_wdata <= cpu_wdata;
            ext_we    <= cpu_we;
            ext_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (ext_ack) begin
            ext_req <= 1'b0;
            if (!ext_we) cpu_rdata <= ext_rdata;
            state   <= DONE;
          end
`ifdef EXT_TIMEOUT_EN
          else if (tmo_hit) begin
            ext_req <= 1'b0;
            if (!ext_we) cpu_rdata <= 32'hFFFF_FFFF;
            bus_err <= 1'b1;
            state   <= DONE;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Scoreboard bench for ext_mem_bridge: expected cpu_rdata queued at issue, popped at DONE.
module tb_ext_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_we, cpu_re;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_rdata;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl_rdata = 32'h0;

  ext_mem_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // One CPU access: hold the request until DONE, ack on the ack_at-th REQ cycle.
  task automatic run_access(input logic we, input logic re, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int ack_at, input int exp_stall, input logic hold_ack);
    int stalls = 0;
    int reqs = 0;
    bit done = 0;
    logic [31:0] exp;
    exp_q.push_back(we ? mdl_rdata : rdata);
    @(posedge clk); #1;
    cs = 1'b1; cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wdata; ext_ack = 1'b0;
    #1;
    checks++;
    if (ext_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", ext_req); end
    if (stall) stalls++;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge clk); #1;
      if (ext_req) begin
        reqs++;
        checks++;
        if ({ext_we, ext_addr, ext_wdata} !== {we, addr, wdata}) begin
          errors++;
          $display("FAIL req_fields: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                   ext_we, ext_addr, ext_wdata, we, addr, wdata);
        end
        if (reqs == ack_at) begin ext_ack = 1'b1; ext_rdata = rdata; end
        #1;
        if (stall) stalls++;
      end else begin
        ext_ack = hold_ack; cs = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0;
        #1;
        done = 1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sb_empty: got empty queue want entry");
        end else begin
          exp = exp_q.pop_front();
          if (cpu_rdata !== exp) begin
            errors++; $display("FAIL done_rdata: got %h want %h", cpu_rdata, exp);
          end
        end
        checks++;
        if ({stall, bus_err} !== 2'b00) begin
          errors++; $display("FAIL done_flags: got stall=%b bus_err=%b want 0 0", stall, bus_err);
        end
        if (!we) mdl_rdata = rdata;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL done_timeout: got no DONE want DONE within 64 cycles"); end
    checks++;
    if (stalls != exp_stall) begin errors++; $display("FAIL stall_cycles: got %0d want %0d", stalls, exp_stall); end
    checks++;
    if (reqs != ack_at) begin errors++; $display("FAIL req_cycles: got %0d want %0d", reqs, ack_at); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs = 1'b1; cpu_re = 1'b1; cpu_we = 1'b0;
    cpu_addr = 32'h0000_3000; cpu_wdata = 32'h0; ext_ack = 1'b0; ext_rdata = 32'h0;
    #12;
    checks++;
    if ({stall, ext_req, ext_we, bus_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl: got %b want 0000", {stall, ext_req, ext_we, bus_err});
    end
    checks++;
    if ({ext_addr, ext_wdata, cpu_rdata} !== 96'h0) begin
      errors++; $display("FAIL reset_data: got %h %h %h want 0", ext_addr, ext_wdata, cpu_rdata);
    end
    @(posedge clk); #1; cs = 1'b0; cpu_re = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_read();
    run_access(1'b0, 1'b1, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 2, 3, 1'b0);
  endtask

  task automatic test_write();
    run_access(1'b1, 1'b0, 32'h0000_1000, 32'h1234_5678, 32'h5555_AAAA, 1, 2, 1'b0);
    run_access(1'b1, 1'b1, 32'h0000_1004, 32'h8765_4321, 32'h7777_7777, 1, 2, 1'b0);
  endtask

  task automatic test_internal();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      cs = 1'b0; cpu_re = 1'b1; cpu_we = c[0]; cpu_addr = 32'h0000_2B10;
      ext_ack = c[1]; ext_rdata = 32'hBAD0_0000 + c;
      #1;
      checks++;
      if ({ext_req, stall} !== 2'b00) begin
        errors++; $display("FAIL internal: got req=%b stall=%b want 0 0", ext_req, stall);
      end
    end
    @(posedge clk); #1; cpu_re = 1'b0; cpu_we = 1'b0; ext_ack = 1'b0; #1;
    checks++;
    if (cpu_rdata !== mdl_rdata) begin
      errors++; $display("FAIL internal_rdata: got %h want %h", cpu_rdata, mdl_rdata);
    end
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 1'b1, 32'h0000_3100, 32'h0, 32'h0102_0304, 1, 2, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      cs = 1'b1; cpu_re = 1'b1; cpu_addr = 32'h0000_3104; ext_ack = 1'b1;
      #1;
      checks++;
      if ({ext_req, stall} !== 2'b01) begin
        errors++; $display("FAIL b2b_blocked: got req=%b stall=%b want 0 1", ext_req, stall);
      end
    end
    run_access(1'b0, 1'b1, 32'h0000_3104, 32'h0, 32'hA5A5_5A5A, 1, 2, 1'b0);
  endtask

  task automatic test_reset_mid_req();
    @(posedge clk); #1;
    cs = 1'b1; cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_4000; ext_ack = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ext_req !== 1'b1) begin errors++; $display("FAIL mid_req_entry: got %b want 1", ext_req); end
    rst_n = 1'b0; ext_ack = 1'b1; ext_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({ext_req, stall} !== 2'b00) begin
      errors++; $display("FAIL mid_rst_ctl: got req=%b stall=%b want 0 0", ext_req, stall);
    end
    checks++;
    if ({cpu_rdata, ext_addr} !== 64'h0) begin
      errors++; $display("FAIL mid_rst_data: got rdata=%h addr=%h want 0 0", cpu_rdata, ext_addr);
    end
    mdl_rdata = 32'h0;
    @(posedge clk); #1; rst_n = 1'b1; #1;
    checks++;
    if ({ext_req, stall} !== 2'b01) begin
      errors++; $display("FAIL rst_linger_ack: got req=%b stall=%b want 0 1", ext_req, stall);
    end
    @(posedge clk); #2;
    checks++;
    if ({ext_req, stall, cpu_rdata} !== {2'b01, 32'h0}) begin
      errors++; $display("FAIL rst_no_capture: got req=%b stall=%b rdata=%h want 0 1 0", ext_req, stall, cpu_rdata);
    end
    run_access(1'b0, 1'b1, 32'h0000_4000, 32'h0, 32'h0BAD_CAFE, 1, 2, 1'b0);
  endtask

`ifdef EXT_TIMEOUT_EN
  task automatic test_timeout();
    int reqs = 0;
    bit done = 0;
    logic [31:0] exp;
    exp_q.push_back(32'hFFFF_FFFF);
    @(posedge clk); #1;
    cs = 1'b1; cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_5000; ext_ack = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge clk); #1;
      if (ext_req) begin
        reqs++;
        #1;
        checks++;
        if (bus_err !== 1'b0) begin errors++; $display("FAIL tmo_early_err: got 1 want 0"); end
      end else begin
        cs = 1'b0; cpu_re = 1'b0; ext_ack = 1'b1;
        #1;
        done = 1;
        exp = exp_q.pop_front();
        checks++;
        if ({cpu_rdata, bus_err, stall} !== {exp, 2'b10}) begin
          errors++; $display("FAIL tmo_done: got rdata=%h err=%b stall=%b want %h 1 0", cpu_rdata, bus_err, stall, exp);
        end
      end
    end
    checks++;
    if (!done || reqs != 16) begin errors++; $display("FAIL tmo_req_cycles: got %0d want 16", reqs); end
    mdl_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1; cs = 1'b1; cpu_re = 1'b1; cpu_addr = 32'h0000_5004; #1;
      checks++;
      if ({bus_err, ext_req, stall} !== 3'b001) begin
        errors++; $display("FAIL late_ack: got err=%b req=%b stall=%b want 0 0 1", bus_err, ext_req, stall);
      end
    end
    run_access(1'b0, 1'b1, 32'h0000_5004, 32'h0, 32'h1111_2222, 1, 2, 1'b0);
    run_access(1'b0, 1'b1, 32'h0000_5008, 32'h0, 32'h3333_4444, 16, 17, 1'b0);
  endtask
`else
  task automatic test_timeout();
    run_access(1'b0, 1'b1, 32'h0000_5000, 32'h0, 32'h1111_2222, 40, 41, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_internal();
    test_back_to_back();
    test_reset_mid_req();
    test_timeout();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
